dff_pwm: RTL and testbench
==========================

// Module: dff_pwm
// PURPOSE
//  Enable-gated D flip-flop bank used as the sampling stage of the PWM generator's
//  push-button debouncer. It captures its input only on cycles where the slow
//  clock-enable tick (about 4 Hz) is high. Two instances in series per button form
//  the debounce pair; the generator derives a one-tick press pulse as q1 & ~q2 & en.
// PARAMETERS
//  WIDTH        1    bit width of d/q (debouncer uses 1)
//  RESET_VALUE  0    value loaded into q while rst_n is low (WIDTH bits, zero-extended)
// PORTS
//  clk    in   1      system clock (100 MHz), all state updates on rising edge
//  rst_n  in   1      asynchronous active-low reset
//  en     in   1      sample enable (slow clock-enable tick, one clk cycle wide)
//  d      in   WIDTH  data to capture
//  q      out  WIDTH  registered data
//  rise   out  WIDTH  per-bit rising-edge pulse (present only with DFF_PWM_RISE_EN)
// BEHAVIOUR
//  - Reset: rst_n low forces q = RESET_VALUE immediately, independent of clk and en.
//    q holds that value for as long as rst_n is low.
//  - rst_n is deasserted synchronously to clk by the system; no internal synchronizer.
//    The first capture is on the first rising clk edge with rst_n high and en = 1.
//  - Rising clk edge, rst_n high, en = 1: q <= d. The new value is visible after that
//    edge (1-cycle latency from the enabled edge).
//  - Rising clk edge, rst_n high, en = 0: q holds its value. Changes on d are ignored.
//  - en held high continuously makes the block a plain D flip-flop.
//  - Reset asserted mid-operation overrides any enabled capture in the same cycle.
//  - All bits are independent. No arithmetic, no wrap-around.
//  - No combinational path from d to q. With DFF_PWM_RISE_EN, rise is combinational
//    from en and the internal registers only.
// CONFIGURATION
//  DFF_PWM_RISE_EN defined:
//    - Adds an internal second register stage q2.
//    - q2 is updated from q on the same enabled edges and is reset to RESET_VALUE.
//    - Adds output rise = q & ~q2 & {WIDTH{en}}: a one-clk pulse on the tick after d
//      goes 0 -> 1 and is sampled.
//  DFF_PWM_RISE_EN undefined:
//    - No q2 register and no rise port.
//    - Block is the bare enabled flop bank.
// TESTING
//  1. rst_n = 0 with d = 1, en = 1, clk toggling -> q stays 0. Release rst_n, next
//     enabled edge -> q = 1.
//  2. rst_n = 1, en = 0, d toggles 0/1 for 20 cycles -> q unchanged (0).
//  3. en pulsed high 1 cycle with d = 1 -> q = 1 from the following cycle. Then d = 0,
//     en = 0 -> q stays 1.
//  4. q = 1, assert rst_n = 0 between clock edges -> q = 0 immediately, without waiting
//     for a clock edge.
//  5. en held at 1, d = 1010... per cycle -> q equals d delayed by exactly 1 cycle.
//  6. DFF_PWM_RISE_EN: d 0 -> 1, two en ticks -> rise = 1 for one cycle on the first
//     tick after capture, 0 on the second. Held button -> no further pulses.

Source files
------------

// File: rtl/dff_pwm.sv
// Enable-gated D flip-flop bank: the sampling stage of the PWM push-button debouncer.
// Optional macro DFF_PWM_RISE_EN adds a second stage and a per-bit rising-edge pulse.
module dff_pwm #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef DFF_PWM_RISE_EN
  ,
  output logic [WIDTH-1:0] rise
`endif
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Capture d only on enable ticks, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef DFF_PWM_RISE_EN
  logic [WIDTH-1:0] q2_q;
  logic [WIDTH-1:0] q2_d;

  // Second stage follows the first on the same enable ticks.
  always_comb begin
    q2_d = q2_q;
    if (en) begin
      q2_d = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2_q <= RESET_VALUE;
    end else begin
      q2_q <= q2_d;
    end
  end

  // Pulse is qualified by en so it lasts exactly one clk cycle per tick.
  assign rise = q_q & ~q2_q & {WIDTH{en}};
`endif

endmodule

// File: tb/tb_dff_pwm.sv
// Directed self-checking bench for dff_pwm: a 1-bit debouncer instance and a
// 4-bit instance with a non-zero reset value sharing clock, reset and enable.
module tb_dff_pwm;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b0;
  logic       d     = 1'b0;
  logic       q;
  logic [3:0] d4    = 4'h0;
  logic [3:0] q4;
`ifdef DFF_PWM_RISE_EN
  logic       rise;
  logic [3:0] rise4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff_pwm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d),
    .q     (q)
`ifdef DFF_PWM_RISE_EN
    ,
    .rise  (rise)
`endif
  );

  dff_pwm #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d4),
    .q     (q4)
`ifdef DFF_PWM_RISE_EN
    ,
    .rise  (rise4)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d     = 1'b1;
    d4    = 4'h5;
    en    = 1'b1;
    #1;
    checks++;
    if (q4 !== 4'hA) begin
      errors++;
      $display("FAIL reset_async_value4: got %h expected %h", q4, 4'hA);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold q cycle %0d: got %b expected 0", i, q);
      end
      checks++;
      if (q4 !== 4'hA) begin
        errors++;
        $display("FAIL reset_hold q4 cycle %0d: got %h expected a", i, q4);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_capture q: got %b expected 1", q);
    end
    checks++;
    if (q4 !== 4'h5) begin
      errors++;
      $display("FAIL reset_release_capture q4: got %h expected 5", q4);
    end
  endtask

  task automatic test_hold();
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d  = 1'(i % 2);
      d4 = 4'(i);
      tick();
      checks++;
      if (q !== 1'b0 || q4 !== 4'hA) begin
        errors++;
        $display("FAIL enable_low_hold cycle %0d: got q=%b q4=%h expected q=0 q4=a", i, q, q4);
      end
    end
  endtask

  task automatic test_pulse();
    d  = 1'b1;
    d4 = 4'h3;
    en = 1'b1;
    tick();
    en = 1'b0;
    d  = 1'b0;
    d4 = 4'hC;
    checks++;
    if (q !== 1'b1 || q4 !== 4'h3) begin
      errors++;
      $display("FAIL single_tick_capture: got q=%b q4=%h expected q=1 q4=3", q, q4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== 1'b1 || q4 !== 4'h3) begin
        errors++;
        $display("FAIL post_tick_hold cycle %0d: got q=%b q4=%h expected q=1 q4=3", i, q, q4);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || q4 !== 4'hA) begin
      errors++;
      $display("FAIL async_reset_midcycle: got q=%b q4=%h expected q=0 q4=a", q, q4);
    end
    d  = 1'b1;
    en = 1'b1;
    tick();
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrides_capture: got %b expected 0", q);
    end
    rst_n = 1'b1;
    en    = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] pat;
    logic [3:0] prev4;
    logic       prev;
    pat   = 10'b1010110010;
    en    = 1'b1;
    d     = 1'b0;
    d4    = 4'h0;
    tick();
    prev  = 1'b0;
    prev4 = 4'h0;
    for (int i = 0; i < 10; i++) begin
      d  = pat[i];
      d4 = {pat[i], ~pat[i], 2'(i)};
      #1;
      checks++;
      if (q !== prev) begin
        errors++;
        $display("FAIL pipe_no_flowthrough step %0d: got %b expected %b", i, q, prev);
      end
      tick();
      checks++;
      if (q !== pat[i] || q4 !== d4) begin
        errors++;
        $display("FAIL pipe_capture step %0d: got q=%b q4=%h expected q=%b q4=%h", i, q, q4, pat[i], d4);
      end
      prev  = pat[i];
      prev4 = d4;
    end
    en = 1'b0;
  endtask

`ifdef DFF_PWM_RISE_EN
  task automatic test_rise();
    en    = 1'b0;
    d     = 1'b0;
    d4    = 4'h3;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    d  = 1'b1;
    en = 1'b1;
    #1;
    checks++;
    if (rise !== 1'b0 || rise4 !== 4'h0) begin
      errors++;
      $display("FAIL rise_tick1: got rise=%b rise4=%h expected 0 0", rise, rise4);
    end
    tick();
    en = 1'b0;
    #1;
    checks++;
    if (rise !== 1'b0 || q !== 1'b1) begin
      errors++;
      $display("FAIL rise_gated_between_ticks: got rise=%b q=%b expected rise=0 q=1", rise, q);
    end
    tick();
    en = 1'b1;
    #1;
    checks++;
    if (rise !== 1'b1 || rise4 !== 4'h1) begin
      errors++;
      $display("FAIL rise_tick2_pulse: got rise=%b rise4=%h expected 1 1", rise, rise4);
    end
    tick();
    en = 1'b0;
    #1;
    checks++;
    if (rise !== 1'b0) begin
      errors++;
      $display("FAIL rise_one_cycle: got %b expected 0", rise);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      en = 1'b1;
      #1;
      checks++;
      if (rise !== 1'b0 || rise4 !== 4'h0) begin
        errors++;
        $display("FAIL rise_held_button tick %0d: got rise=%b rise4=%h expected 0 0", i, rise, rise4);
      end
      tick();
      en = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hold();
    test_pulse();
    test_async_reset();
    test_back_to_back();
`ifdef DFF_PWM_RISE_EN
    test_rise();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
